mips_multicycle_ctrl: RTL

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute steps.
// Write enables are held off while reset is asserted; everything else shows the FETCH decode.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero_F,
    output logic [2:0]         ALU_control,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               PCEn,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [STATE_W-1:0] state_q, state_d;
    logic               pc_write, branch, ir_write, mem_write, reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALU_control = 3'b000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1; pc_write = 1'b1; ALUSrcB = 2'b01; ALU_control = 3'b010;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11; ALU_control = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_control = 3'b010;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                reg_write = 1'b1; MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD = 1'b1; mem_write = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100010: ALU_control = 3'b110;
                    6'b100100: ALU_control = 3'b000;
                    6'b100101: ALU_control = 3'b001;
                    6'b101010: ALU_control = 3'b111;
                    default:   ALU_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1; RegDst = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1; ALU_control = 3'b110; PCSrc = 2'b01; branch = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10; pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // rst_n gating keeps reset-time FETCH from writing PC/IR while the rest of FETCH is visible
    assign IRWrite  = ir_write  & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign RegWrite = reg_write & rst_n;
    assign PCEn     = (pc_write | (branch & zero_F)) & rst_n;
    assign state    = state_q;

endmodule
